// File: rtl/dh_link_pkg.sv
// Shared definitions for the two-board player link (receive and transmit sides).
package dh_link_pkg;
   localparam int SCORE_W_DEF       = 4;
   localparam int STABLE_CYCLES_DEF = 65000;

   // Field positions on the JC/JB headers, shared with the transmitter.
   localparam int JC_SCORE_LSB  = 0;
   localparam int JC_SCORE_MSB  = 3;
   localparam int JC_PAUSE_BIT  = 4;
   localparam int JC_RELOAD_BIT = 5;
   localparam int JC_W          = 6;
endpackage

// File: rtl/player2_link_rx_if.sv
// Partner-pin levels in, filtered levels and event pulses out.
interface player2_link_rx_if import dh_link_pkg::*; #(
   parameter int SCORE_W = SCORE_W_DEF
);
   logic               pause_raw;
   logic               reload_raw;
   logic [SCORE_W-1:0] score_raw;
   logic               pause;
   logic               pause_rise;
   logic               pause_fall;
   logic               reload;
   logic               reload_pulse;
   logic [SCORE_W-1:0] score;
   logic               score_changed;
   logic               link_ready;

   modport master (
      output pause_raw, reload_raw, score_raw,
      input  pause, pause_rise, pause_fall, reload, reload_pulse,
             score, score_changed, link_ready
   );

   modport slave (
      input  pause_raw, reload_raw, score_raw,
      output pause, pause_rise, pause_fall, reload, reload_pulse,
             score, score_changed, link_ready
   );
endinterface

// File: rtl/player2_link_rx_filter.sv
// Synchronizer plus stability filter: a value is committed only after it has
// held unchanged for STABLE_CYCLES cycles.
module link_filter import dh_link_pkg::*; #(
   parameter int W             = 1,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] out_o,
   output logic         commit_o,
   output logic         stable_o
);
   localparam int              CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [W-1:0]     sync1_q, sync2_q;
   logic [1:0]       vld_q;
   logic             loaded_q, loaded_d;
   logic [W-1:0]     cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     out_q, out_d;
   logic             commit;

   // The synchronizer contents are not trusted until both stages hold a real
   // sample; the first trusted value is always loaded as a fresh candidate.
   always_comb begin
      loaded_d = loaded_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      commit   = 1'b0;
      if (vld_q[1]) begin
         if (!loaded_q || (sync2_q != cand_q)) begin
            cand_d   = sync2_q;
            cnt_d    = '0;
            loaded_d = 1'b1;
         end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end else if (out_q != cand_q) begin
            out_d  = cand_q;
            commit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         vld_q    <= '0;
         loaded_q <= 1'b0;
         cand_q   <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         vld_q    <= {vld_q[0], 1'b1};
         loaded_q <= loaded_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
      end
   end

   assign out_o    = out_q;
   assign commit_o = commit;
   assign stable_o = loaded_q && (cnt_q == CNT_MAX);
endmodule

// File: rtl/player2_link_rx.sv
// Receive side of the player link: filters partner levels and raises event
// pulses once the link has settled.
module player2_link_rx import dh_link_pkg::*; #(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int SCORE_W       = SCORE_W_DEF
) (
   input  logic              clk_sys,
   input  logic              rst_b,
   player2_link_rx_if.slave  link
);
   logic               pause_out, pause_commit, pause_stable;
   logic               reload_out, reload_commit, reload_stable;
   logic [SCORE_W-1:0] score_out;
   logic               score_commit, score_stable;

   logic link_ready_q, link_ready_d;
   logic pause_rise_q, pause_rise_d;
   logic pause_fall_q, pause_fall_d;
   logic reload_pulse_q, reload_pulse_d;
   logic score_changed_q, score_changed_d;

   link_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_pause (
      .clk_sys  (clk_sys),
      .rst_b    (rst_b),
      .raw_i    (link.pause_raw),
      .out_o    (pause_out),
      .commit_o (pause_commit),
      .stable_o (pause_stable)
   );

   link_filter #(.W(1), .STABLE_CYCLES(STABLE_CYCLES)) u_reload (
      .clk_sys  (clk_sys),
      .rst_b    (rst_b),
      .raw_i    (link.reload_raw),
      .out_o    (reload_out),
      .commit_o (reload_commit),
      .stable_o (reload_stable)
   );

   link_filter #(.W(SCORE_W), .STABLE_CYCLES(STABLE_CYCLES)) u_score (
      .clk_sys  (clk_sys),
      .rst_b    (rst_b),
      .raw_i    (link.score_raw),
      .out_o    (score_out),
      .commit_o (score_commit),
      .stable_o (score_stable)
   );

   // A commit always flips a 1-bit level, so the current value gives direction.
   // Pulses are gated by last cycle's ready to hide the partner's power-up state.
   always_comb begin
      link_ready_d    = link_ready_q | (pause_stable & reload_stable & score_stable);
      pause_rise_d    = link_ready_q & pause_commit & ~pause_out;
      pause_fall_d    = link_ready_q & pause_commit & pause_out;
      reload_pulse_d  = link_ready_q & reload_commit & ~reload_out;
      score_changed_d = link_ready_q & score_commit;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         link_ready_q    <= 1'b0;
         pause_rise_q    <= 1'b0;
         pause_fall_q    <= 1'b0;
         reload_pulse_q  <= 1'b0;
         score_changed_q <= 1'b0;
      end else begin
         link_ready_q    <= link_ready_d;
         pause_rise_q    <= pause_rise_d;
         pause_fall_q    <= pause_fall_d;
         reload_pulse_q  <= reload_pulse_d;
         score_changed_q <= score_changed_d;
      end
   end

   assign link.pause         = pause_out;
   assign link.pause_rise    = pause_rise_q;
   assign link.pause_fall    = pause_fall_q;
   assign link.reload        = reload_out;
   assign link.reload_pulse  = reload_pulse_q;
   assign link.score         = score_out;
   assign link.score_changed = score_changed_q;
   assign link.link_ready    = link_ready_q;
endmodule

// File: tb/tb_player2_link_rx.sv
// Self-checking bench for player2_link_rx with a short stability window.
module tb_player2_link_rx;
   localparam int SC = 4;

   logic clk_sys = 1'b0;
   logic rst_b   = 1'b0;

   player2_link_rx_if #(.SCORE_W(4)) lk ();

   player2_link_rx #(.STABLE_CYCLES(SC), .SCORE_W(4)) dut (
      .clk_sys (clk_sys),
      .rst_b   (rst_b),
      .link    (lk)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic       p;
      logic       r;
      logic [3:0] s;
      int         hold;
      logic       ep;
      logic       er;
      logic [3:0] es;
      int         n_rise;
      int         n_fall;
      int         n_rp;
      int         n_sc;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   int tot_rise = 0, tot_fall = 0, tot_rp = 0, tot_sc = 0;
   bit seen7 = 1'b0;

   always @(negedge clk_sys) begin
      if (lk.pause_rise)    tot_rise++;
      if (lk.pause_fall)    tot_fall++;
      if (lk.reload_pulse)  tot_rp++;
      if (lk.score_changed) tot_sc++;
      if (lk.score == 4'd7) seen7 = 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic vec_t mk(input logic p, input logic r, input logic [3:0] s, input int hold,
                               input logic ep, input logic er, input logic [3:0] es,
                               input int nr, input int nf, input int nrp, input int nsc);
      vec_t v;
      v.p = p; v.r = r; v.s = s; v.hold = hold;
      v.ep = ep; v.er = er; v.es = es;
      v.n_rise = nr; v.n_fall = nf; v.n_rp = nrp; v.n_sc = nsc;
      return v;
   endfunction

   // Release reset (already asserted, raws set) and check the power-up commit.
   task automatic release_seq(input logic p, input logic [3:0] s);
      int t0;
      t0 = tot_rise + tot_fall + tot_rp + tot_sc;
      rst_b = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk($sformatf("ready_e%0d", e), lk.link_ready, (e >= 7));
         chk($sformatf("pause_e%0d", e), lk.pause, (e >= 7) ? p : 1'b0);
         chk($sformatf("score_e%0d", e), lk.score, (e >= 7) ? s : 4'd0);
      end
      chk("powerup_pulses", tot_rise + tot_fall + tot_rp + tot_sc - t0, 0);
      chk("powerup_reload", lk.reload, 0);
   endtask

   vec_t vecs[$];
   vec_t sb[$];

   initial begin
      vec_t exp;
      int b_rise, b_fall, b_rp, b_sc;

      vecs.push_back(mk(0, 1, 4'd0,  3, 0, 0, 4'd0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'd0, 10, 0, 0, 4'd0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4'd0, 10, 0, 1, 4'd0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 4'd0, 10, 0, 1, 4'd0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'd0, 10, 0, 0, 4'd0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'd3, 10, 0, 0, 4'd3, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 4'd7,  1, 0, 0, 4'd3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'd4, 10, 0, 0, 4'd4, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 4'd4, 10, 1, 0, 4'd4, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'd4, 10, 0, 0, 4'd4, 0, 1, 0, 0));
      vecs.push_back(mk(1, 1, 4'd9, 10, 1, 1, 4'd9, 1, 0, 1, 1));
      vecs.push_back(mk(0, 1, 4'd9,  2, 1, 1, 4'd9, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'd9, 10, 1, 1, 4'd9, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'd2,  3, 1, 1, 4'd9, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'd9, 10, 1, 1, 4'd9, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'd0, 10, 0, 0, 4'd0, 0, 1, 0, 1));

      lk.pause_raw  = 1'b0;
      lk.reload_raw = 1'b0;
      lk.score_raw  = 4'd0;
      repeat (3) tick();
      chk("rst_ready", lk.link_ready, 0);
      chk("rst_pause", lk.pause, 0);
      chk("rst_score", lk.score, 0);

      release_seq(1'b0, 4'd0);
      repeat (3) tick();

      for (int i = 0; i < vecs.size(); i++) begin
         lk.pause_raw  = vecs[i].p;
         lk.reload_raw = vecs[i].r;
         lk.score_raw  = vecs[i].s;
         sb.push_back(vecs[i]);
         b_rise = tot_rise; b_fall = tot_fall; b_rp = tot_rp; b_sc = tot_sc;
         repeat (vecs[i].hold) tick();
         exp = sb.pop_front();
         chk($sformatf("v%0d.pause", i),  lk.pause,  exp.ep);
         chk($sformatf("v%0d.reload", i), lk.reload, exp.er);
         chk($sformatf("v%0d.score", i),  lk.score,  exp.es);
         chk($sformatf("v%0d.n_rise", i), tot_rise - b_rise, exp.n_rise);
         chk($sformatf("v%0d.n_fall", i), tot_fall - b_fall, exp.n_fall);
         chk($sformatf("v%0d.n_rp", i),   tot_rp - b_rp,     exp.n_rp);
         chk($sformatf("v%0d.n_sc", i),   tot_sc - b_sc,     exp.n_sc);
      end

      // Reload pulse lands exactly on edge 7 and lasts one cycle.
      lk.reload_raw = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk($sformatf("rp_e%0d", e), lk.reload_pulse, (e == 7));
         chk($sformatf("rl_e%0d", e), lk.reload, (e >= 7));
      end
      lk.reload_raw = 1'b0;
      repeat (10) tick();

      // Nonzero levels present at reset release commit without pulses.
      rst_b = 1'b0;
      lk.pause_raw = 1'b1;
      lk.score_raw = 4'd5;
      repeat (2) tick();
      release_seq(1'b1, 4'd5);

      // Reset mid-count while outputs are nonzero.
      lk.pause_raw = 1'b0;
      repeat (10) tick();
      chk("pre_rst_score", lk.score, 5);
      lk.pause_raw = 1'b1;
      repeat (4) tick();
      rst_b = 1'b0;
      #1;
      chk("midrst_pause", lk.pause, 0);
      chk("midrst_score", lk.score, 0);
      chk("midrst_ready", lk.link_ready, 0);
      lk.pause_raw = 1'b0;
      lk.score_raw = 4'd0;
      tick();
      tick();
      release_seq(1'b0, 4'd0);

      chk("score_never_7", seen7, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
